// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, mid-bit sampling, valid/ready output with framing/overrun flags.
// Optional even parity bit after the data bits when UART_RX_PARITY_EN is defined (adds parity_error).
module uart_rx #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 115_200,
  parameter int DATA_BITS     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_error,
  output logic                 overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_error
`endif
);

  localparam int DIV  = CLK_FREQUENCY / BAUD_RATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV) + 1;
  localparam int BW   = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_ZERO  = '0;
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [BW-1:0] BIT_ZERO  = '0;
  localparam logic [BW-1:0] BIT_ONE   = {{(BW-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  state_t               state_reg;
  logic [CW-1:0]        cnt_reg;
  logic [BW-1:0]        bit_idx_reg;
  logic [1:0]           sync_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 commit_reg;
  logic                 rx_s;
  logic                 data_sample;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bit_reg;
  logic                 perr_pend_reg;
`endif

  assign rx_s        = sync_reg[1];
  assign data_sample = (state_reg == DATA) && (cnt_reg == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rx_serial};
    end
  end

  // Each data bit captures the synchronised line on its own mid-bit strobe.
  for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shift
    always_ff @(posedge clk) begin
      if (rst) begin
        shift_reg[gi] <= 1'b0;
      end else if (data_sample && (bit_idx_reg == BW'(gi))) begin
        shift_reg[gi] <= rx_s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= CNT_ZERO;
      bit_idx_reg    <= BIT_ZERO;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      frame_error    <= 1'b0;
      overrun        <= 1'b0;
      commit_reg     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_reg <= 1'b0;
      perr_pend_reg  <= 1'b0;
      parity_error   <= 1'b0;
`endif
    end else begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      commit_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_pend_reg <= 1'b0;
      parity_error  <= perr_pend_reg;
`endif

      // A word that completes during an accept replaces the accepted one.
      if (commit_reg) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift_reg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (!rx_s) begin
            state_reg <= START;
            cnt_reg   <= CNT_ZERO;
          end
        end
        START: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_reg     <= CNT_ZERO;
            bit_idx_reg <= BIT_ZERO;
            state_reg   <= rx_s ? IDLE : DATA;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt_reg == DIV_LAST) begin
            cnt_reg <= CNT_ZERO;
            if (bit_idx_reg == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_reg <= PARITY;
`else
              state_reg <= STOP;
`endif
            end else begin
              bit_idx_reg <= bit_idx_reg + BIT_ONE;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_reg == DIV_LAST) begin
            cnt_reg        <= CNT_ZERO;
            parity_bit_reg <= rx_s;
            state_reg      <= STOP;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
`endif
        STOP: begin
          if (cnt_reg == DIV_LAST) begin
            cnt_reg <= CNT_ZERO;
            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
              if (^{shift_reg, parity_bit_reg}) begin
                perr_pend_reg <= 1'b1;
              end else begin
                commit_reg <= 1'b1;
              end
`else
              commit_reg <= 1'b1;
`endif
              state_reg <= IDLE;
            end else begin
              frame_error <= 1'b1;
              state_reg   <= WAIT_IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a frame-level model predicts delivered words and error pulses,
// a negedge compare process checks every output word against it.
module tb_uart_rx;
  localparam int DIV  = 16;
  localparam int HALF = 8;
  localparam int DB   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_serial = 1'b1;
  logic          rx_ready = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_error;
  logic          overrun;
`ifdef UART_RX_PARITY_EN
  logic          parity_error;
`endif

  uart_rx #(
    .CLK_FREQUENCY(16),
    .BAUD_RATE    (1),
    .DATA_BITS    (DB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_serial  (rx_serial),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_error(frame_error),
    .overrun    (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_error(parity_error)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame-level model state
  logic [DB-1:0] exp_q[$];
  int   exp_ferr = 0;
  int   exp_ovr  = 0;
  int   obs_ferr = 0;
  int   obs_ovr  = 0;
  bit   m_held   = 1'b0;
  logic [DB-1:0] m_data = '0;
  int   lat_start = -1;
  int   lat_meas  = -1;
  bit   p_valid = 1'b0;
  bit   p_hs    = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", name, act);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end else begin
      $display("[TB] ok %s = %0d", name, act);
    end
  endtask

  // Compare process: every new word must be the model's next word; while held it must not change.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_error === 1'b1) obs_ferr++;
      if (overrun === 1'b1) obs_ovr++;
      if (rx_valid === 1'b1 && (!p_valid || p_hs)) begin
        if (lat_start >= 0) begin
          lat_meas  = cyc - lat_start;
          lat_start = -1;
        end
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", rx_data);
        end else begin
          m_data = exp_q.pop_front();
          check("word", int'(rx_data), int'(m_data));
        end
      end else if (rx_valid === 1'b1) begin
        tests++;
        if (rx_data !== m_data) begin
          fails++;
          $display("FAIL held_data: got 0x%0h, expected 0x%0h", rx_data, m_data);
        end
      end
    end
    p_valid = (rx_valid === 1'b1);
    p_hs    = (rx_valid === 1'b1) && (rx_ready === 1'b1);
  end

  task automatic idle(input int n);
    rx_serial = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_serial = b;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DB-1:0] data, input logic stop_b, input bit time_it);
    if (!stop_b) exp_ferr++;
    else if (m_held && !rx_ready) exp_ovr++;
    else begin
      exp_q.push_back(data);
      m_held = !rx_ready;
    end
    if (time_it) lat_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(data[i]);
    drive_bit(stop_b);
  endtask

  task automatic checkpoint(input string tag);
    $display("[TB] checkpoint %s", tag);
    check("frame_error_pulses", obs_ferr, exp_ferr);
    check("overrun_pulses", obs_ovr, exp_ovr);
    check("undelivered_words", exp_q.size(), 0);
  endtask

  initial begin
    #(200_000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_rx_valid", int'(rx_valid), 0);
    check("reset_frame_error", int'(frame_error), 0);
    check("reset_overrun", int'(overrun), 0);
    rst = 1'b0;
    idle(4);

    // Single good frame, with latency from the falling edge
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(3 * DIV);
    checkpoint("A5");
    check_range("latency", lat_meas, 2 + HALF + 9 * DIV, 2 + HALF + 9 * DIV + 2);
    check("data_A5", int'(rx_data), 8'hA5);

    // Short low glitch must be rejected
    rx_serial = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(3 * DIV);
    checkpoint("glitch");

    // Bad stop bit, then recovery
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(2 * DIV);
    checkpoint("framing");
    send_frame(8'h55, 1'b1, 1'b0);
    idle(3 * DIV);
    checkpoint("55");
    check("data_55", int'(rx_data), 8'h55);

    // Back-to-back frames
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(3 * DIV);
    checkpoint("back_to_back");
    check("data_FF", int'(rx_data), 8'hFF);

    // Backpressure: second word dropped with overrun
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    idle(3 * DIV);
    checkpoint("overrun");
    check("data_held_11", int'(rx_data), 8'h11);
    check("valid_held", int'(rx_valid), 1);

    // Reset in the middle of data bit 3
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0);
    rx_serial = 1'b0;
    repeat (HALF) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    rx_serial = 1'b1;
    m_held    = 1'b0;
    check("midreset_rx_data", int'(rx_data), 0);
    check("midreset_rx_valid", int'(rx_valid), 0);
    check("midreset_frame_error", int'(frame_error), 0);
    check("midreset_overrun", int'(overrun), 0);
    rx_ready = 1'b1;
    idle(12 * DIV);
    checkpoint("after_reset_idle");
    send_frame(8'h81, 1'b1, 1'b0);
    idle(3 * DIV);
    checkpoint("81");
    check("data_81", int'(rx_data), 8'h81);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
